// File: rtl/uart_time_reporter.sv
// Snapshots NUM_FIELDS two-digit time fields and streams them into the UART TX FIFO
// as one ASCII line "FF:..:FF" CR LF, on request or periodically from the 100 Hz tick.
module uart_time_reporter #(
   parameter int unsigned NUM_FIELDS   = 4,
   parameter int unsigned FIELD_WIDTH  = 7,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned PERIOD_TICKS = 100,
   parameter logic [7:0]  SEP_CHAR     = 8'h3A
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              tick_100hz,
   input  logic                              auto_en,
   input  logic                              req,
   input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] fields_in,
   input  logic                              tx_full,
   output logic                              tx_push,
   output logic [DATA_WIDTH-1:0]             tx_data,
   output logic                              busy,
   output logic [7:0]                        drop_cnt
);

   localparam int unsigned SNAP_W = NUM_FIELDS * FIELD_WIDTH;
   localparam int unsigned IDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int unsigned CNT_W  = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_FIELDS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_TICKS - 1);
   localparam logic [7:0]       ASCII_0   = 8'h30;
   localparam logic [7:0]       ASCII_CR  = 8'h0D;
   localparam logic [7:0]       ASCII_LF  = 8'h0A;
   localparam logic [7:0]       DROP_MAX  = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TENS = 3'd1,
      S_ONES = 3'd2,
      S_SEP  = 3'd3,
      S_CR   = 3'd4,
      S_LF   = 3'd5
   } state_t;

   state_t              state;
   logic [SNAP_W-1:0]   snapshot;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    period_cnt;

   logic                auto_hit;
   logic                trig;
   logic [FIELD_WIDTH-1:0] field_raw;
   logic [6:0]          field_sat;
   logic [3:0]          tens;
   logic [3:0]          ones;
   logic [7:0]          line_byte;

   // Trigger sources; a request and a periodic hit in the same cycle are one trigger
   assign auto_hit = auto_en & tick_100hz & (period_cnt == CNT_LAST);
   assign trig     = req | auto_hit;

   // Flow control: a byte is offered whenever a line is active and the FIFO has room
   assign busy    = (state != S_IDLE);
   assign tx_push = busy & ~tx_full;

   // Current field from the frozen snapshot, saturated to 99 and split into digits
   always_comb begin
      field_raw = snapshot[32'(idx) * FIELD_WIDTH +: FIELD_WIDTH];
      if (32'(field_raw) > 32'd99) begin
         field_sat = 7'd99;
      end else begin
         field_sat = 7'(field_raw);
      end
      tens = 4'(field_sat / 7'd10);
      ones = 4'(field_sat % 7'd10);
   end

   // Byte for the current state; zero while idle
   always_comb begin
      line_byte = 8'h00;
      unique case (state)
         S_TENS:  line_byte = ASCII_0 + {4'h0, tens};
         S_ONES:  line_byte = ASCII_0 + {4'h0, ones};
         S_SEP:   line_byte = SEP_CHAR;
         S_CR:    line_byte = ASCII_CR;
         S_LF:    line_byte = ASCII_LF;
         default: line_byte = 8'h00;
      endcase
   end

   assign tx_data = DATA_WIDTH'(line_byte);

   // Line sequencer; every non-idle state advances only on a cycle that pushed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         snapshot <= '0;
         idx      <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (trig) begin
                  snapshot <= fields_in;
                  idx      <= IDX_LAST;
                  state    <= S_TENS;
               end
            end
            S_TENS: begin
               if (tx_push) state <= S_ONES;
            end
            S_ONES: begin
               if (tx_push) state <= (idx == '0) ? S_CR : S_SEP;
            end
            S_SEP: begin
               if (tx_push) begin
                  idx   <= idx - IDX_W'(1);
                  state <= S_TENS;
               end
            end
            S_CR: begin
               if (tx_push) state <= S_LF;
            end
            S_LF: begin
               if (tx_push) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Periodic report counter; runs regardless of busy, cleared while disabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_cnt <= '0;
      end else if (!auto_en) begin
         period_cnt <= '0;
      end else if (tick_100hz) begin
         period_cnt <= auto_hit ? '0 : period_cnt + CNT_W'(1);
      end
   end

   // Triggers arriving while a line is in flight are dropped and counted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= '0;
      end else if (trig && busy && (drop_cnt != DROP_MAX)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Self-checking bench for uart_time_reporter: vector table, random lines against a
// line-building reference model, periodic triggering, drops, and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_time_reporter;

   localparam int unsigned NF       = 4;
   localparam int unsigned FW       = 7;
   localparam int unsigned PT       = 3;
   localparam int unsigned FIELDS_W = NF * FW;

   typedef logic [7:0] byte_q_t [$];

   typedef struct packed {
      logic [6:0]  f3;
      logic [6:0]  f2;
      logic [6:0]  f1;
      logic [6:0]  f0;
      logic [87:0] txt;
      logic [7:0]  stall_at;
      logic [7:0]  stall_len;
   } vec_t;

   logic                clk;
   logic                rst_n;
   logic                tick_100hz;
   logic                auto_en;
   logic                req;
   logic [FIELDS_W-1:0] fields_in;
   logic                tx_full;
   logic                tx_push;
   logic [7:0]          tx_data;
   logic                busy;
   logic [7:0]          drop_cnt;

   logic                s_push;
   logic [7:0]          s_data;
   logic                s_busy;
   logic [7:0]          s_drop;

   int checks   = 0;
   int failures = 0;

   uart_time_reporter #(
      .NUM_FIELDS   (NF),
      .FIELD_WIDTH  (FW),
      .DATA_WIDTH   (8),
      .PERIOD_TICKS (PT),
      .SEP_CHAR     (8'h3A)
   ) dut (
      .clk        (clk),
      .rst        (rst_n),
      .tick_100hz (tick_100hz),
      .auto_en    (auto_en),
      .req        (req),
      .fields_in  (fields_in),
      .tx_full    (tx_full),
      .tx_push    (tx_push),
      .tx_data    (tx_data),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string name, input longint unsigned act, input longint unsigned want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, want);
      end
   endtask

   function automatic string q_hex(input byte_q_t q);
      string s;
      s = "";
      foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
      return s;
   endfunction

   task automatic chk_q(input string name, input byte_q_t act, input byte_q_t want);
      bit ok;
      ok = (act.size() == want.size());
      if (ok) foreach (want[i]) if (act[i] !== want[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=[%s] required=[%s]", name, q_hex(act), q_hex(want));
      end
   endtask

   function automatic logic [FIELDS_W-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
      logic [FIELDS_W-1:0] p;
      p = '0;
      p[3*FW +: FW] = FW'(a3);
      p[2*FW +: FW] = FW'(a2);
      p[1*FW +: FW] = FW'(a1);
      p[0*FW +: FW] = FW'(a0);
      return p;
   endfunction

   // Reference: print each field (highest first) as two saturated decimal digits
   function automatic byte_q_t model_line(input logic [FIELDS_W-1:0] f);
      byte_q_t q;
      int      v;
      for (int k = NF - 1; k >= 0; k--) begin
         v = int'(f[k*FW +: FW]);
         if (v > 99) v = 99;
         q.push_back(8'(48 + v / 10));
         q.push_back(8'(48 + v % 10));
         if (k != 0) q.push_back(8'h3A);
      end
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   function automatic byte_q_t txt_line(input logic [87:0] t);
      byte_q_t q;
      for (int i = 0; i < 11; i++) q.push_back(t[(10 - i) * 8 +: 8]);
      q.push_back(8'h0D);
      q.push_back(8'h0A);
      return q;
   endfunction

   // Inputs are set at posedge+1, outputs sampled at posedge+2
   task automatic cyc();
      #1;
      s_push = tx_push;
      s_data = tx_data;
      s_busy = busy;
      s_drop = drop_cnt;
      @(posedge clk);
      #1;
   endtask

   // Collect one line until busy falls, optionally stalling after stall_at bytes
   task automatic drain(input byte_q_t exp, input int stall_at, input int stall_len, input string name);
      byte_q_t got;
      int      n      = 0;
      int      stalls = 0;
      int      gaps   = 0;
      bit      done   = 1'b0;
      for (int c = 0; c < 400; c++) begin
         fields_in = FIELDS_W'($urandom);
         tx_full   = (stall_len > 0) && (got.size() == stall_at) && (stalls < stall_len);
         cyc();
         if (!s_busy) begin
            done = 1'b1;
            break;
         end
         n++;
         if (tx_full) begin
            stalls++;
            chk_eq({name, " stall push"}, 64'(s_push), 64'(0));
            chk_eq({name, " stall data"}, 64'(s_data), 64'(exp[got.size()]));
         end else if (s_push) begin
            got.push_back(s_data);
         end else begin
            gaps++;
         end
      end
      tx_full = 1'b0;
      chk_eq({name, " done"}, 64'(done), 64'(1));
      chk_eq({name, " busy cycles"}, 64'(n), 64'(exp.size() + stall_len));
      chk_eq({name, " gaps"}, 64'(gaps), 64'(0));
      chk_q({name, " bytes"}, got, exp);
      if (done) begin
         chk_eq({name, " idle data"}, 64'(s_data), 64'(0));
         chk_eq({name, " idle push"}, 64'(s_push), 64'(0));
      end
   endtask

   task automatic do_line(input logic [FIELDS_W-1:0] f, input byte_q_t exp, input int stall_at,
                          input int stall_len, input string name);
      fields_in = f;
      req       = 1'b1;
      cyc();
      req = 1'b0;
      chk_eq({name, " trig busy"}, 64'(s_busy), 64'(0));
      drain(exp, stall_at, stall_len, name);
   endtask

   vec_t    vecs [5];
   byte_q_t got;
   int      exp_start [$];
   int      obs_start [$];
   int      cnt;
   int      pushes;
   int      exp_drop;
   bit      prev_busy;
   logic [FIELDS_W-1:0] f;

   initial begin
      vecs[0] = '{f3: 7'd12,  f2: 7'd34,  f1: 7'd56,  f0: 7'd78,  txt: "12:34:56:78", stall_at: 8'd0, stall_len: 8'd0};
      vecs[1] = '{f3: 7'd12,  f2: 7'd34,  f1: 7'd56,  f0: 7'd78,  txt: "12:34:56:78", stall_at: 8'd3, stall_len: 8'd5};
      vecs[2] = '{f3: 7'd0,   f2: 7'd9,   f1: 7'd100, f0: 7'd127, txt: "00:09:99:99", stall_at: 8'd0, stall_len: 8'd0};
      vecs[3] = '{f3: 7'd99,  f2: 7'd0,   f1: 7'd10,  f0: 7'd1,   txt: "99:00:10:01", stall_at: 8'd12, stall_len: 8'd2};
      vecs[4] = '{f3: 7'd127, f2: 7'd127, f1: 7'd127, f0: 7'd127, txt: "99:99:99:99", stall_at: 8'd0, stall_len: 8'd1};

      rst_n = 1'b0; tick_100hz = 1'b0; auto_en = 1'b0; req = 1'b0;
      fields_in = '0; tx_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset busy", 64'(busy), 64'(0));
      chk_eq("reset push", 64'(tx_push), 64'(0));
      rst_n = 1'b1;
      cyc();
      chk_eq("post-reset data", 64'(s_data), 64'(0));
      chk_eq("post-reset drop", 64'(s_drop), 64'(0));
      chk_eq("post-reset busy", 64'(s_busy), 64'(0));

      // Table-driven lines
      for (int i = 0; i < 5; i++) begin
         f = pack4(int'(vecs[i].f3), int'(vecs[i].f2), int'(vecs[i].f1), int'(vecs[i].f0));
         do_line(f, txt_line(vecs[i].txt), int'(vecs[i].stall_at), int'(vecs[i].stall_len),
                 $sformatf("vec%0d", i));
      end
      chk_eq("table drop", 64'(s_drop), 64'(0));

      // Random lines with random backpressure
      for (int i = 0; i < 15; i++) begin
         f = pack4(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
         do_line(f, model_line(f), int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
                 $sformatf("rnd%0d", i));
      end

      // Periodic reporting: hit on every PT-th enabled tick, count cleared while disabled
      cnt = 0; pushes = 0; prev_busy = 1'b0;
      for (int c = 0; c < 180; c++) begin
         auto_en    = !(c >= 70 && c < 100);
         tick_100hz = (c % 10 == 5);
         fields_in  = FIELDS_W'($urandom);
         if (!auto_en) cnt = 0;
         else if (tick_100hz) begin
            cnt++;
            if (cnt == PT) begin
               exp_start.push_back(c + 1);
               cnt = 0;
            end
         end
         cyc();
         if (s_busy && !prev_busy) obs_start.push_back(c);
         if (s_push) pushes++;
         prev_busy = s_busy;
      end
      auto_en = 1'b0; tick_100hz = 1'b0;
      chk_eq("auto lines", 64'(obs_start.size()), 64'(exp_start.size()));
      for (int i = 0; i < exp_start.size() && i < obs_start.size(); i++)
         chk_eq($sformatf("auto start%0d", i), 64'(obs_start[i]), 64'(exp_start[i]));
      chk_eq("auto pushes", 64'(pushes), 64'(13 * exp_start.size()));
      chk_eq("auto drop", 64'(s_drop), 64'(0));

      // Asynchronous reset after the fourth byte
      fields_in = pack4(11, 22, 33, 44);
      req = 1'b1;
      cyc();
      req = 1'b0; pushes = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (s_push) pushes++;
      end
      chk_eq("pre-reset pushes", 64'(pushes), 64'(4));
      rst_n = 1'b0;
      #1;
      chk_eq("async rst push", 64'(tx_push), 64'(0));
      chk_eq("async rst busy", 64'(busy), 64'(0));
      chk_eq("async rst data", 64'(tx_data), 64'(0));
      cyc();
      cyc();
      rst_n = 1'b1;
      pushes = 0; cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (s_push) pushes++;
         if (s_busy) cnt++;
      end
      chk_eq("residual pushes", 64'(pushes), 64'(0));
      chk_eq("residual busy", 64'(cnt), 64'(0));
      f = pack4(5, 6, 7, 8);
      do_line(f, model_line(f), 0, 0, "post-rst");
      chk_eq("post-rst drop", 64'(s_drop), 64'(0));

      // Rejected requests at T+3, T+5 and on the LF push
      f = pack4(1, 2, 3, 4);
      fields_in = f;
      req = 1'b1;
      cyc();
      got.delete();
      for (int i = 1; i <= 13; i++) begin
         req = (i == 3) || (i == 5) || (i == 13);
         cyc();
         if (s_push) got.push_back(s_data);
      end
      req = 1'b0;
      chk_eq("lf push", 64'(s_push), 64'(1));
      chk_eq("lf data", 64'(s_data), 64'(8'h0A));
      chk_q("drop line bytes", got, model_line(f));
      f = pack4(9, 8, 7, 6);
      do_line(f, model_line(f), 0, 0, "after-drop");
      chk_eq("drop count", 64'(s_drop), 64'(3));

      // Saturation: hold the FIFO full and keep requesting
      exp_drop = 3;
      f = pack4(42, 17, 3, 88);
      fields_in = f;
      req = 1'b1; tx_full = 1'b1;
      cyc();
      pushes = 0;
      for (int i = 0; i < 300; i++) begin
         req = 1'b1; tx_full = 1'b1;
         cyc();
         if (s_push) pushes++;
         if (i == 100) chk_eq("drop mid", 64'(s_drop), 64'(exp_drop + 100));
      end
      req = 1'b0;
      cyc();
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      chk_eq("full pushes", 64'(pushes), 64'(0));
      chk_eq("drop sat", 64'(s_drop), 64'(exp_drop));
      drain(model_line(f), 0, 0, "sat-drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
